// File: rtl/mem_stage.sv
// Memory-access stage: byte/half/word loads and stores against a word-organised
// data memory built from four byte-lane RAMs. Load data is sign/zero extended.
// Misaligned, out-of-range and illegal accesses are rejected without side effects.
// All MEM-side outputs are registered (one cycle from the EX inputs).

// One byte lane of the data memory: a write-enabled byte array with a
// combinational read on the same index.
module mem_stage_lane #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);
  logic [7:0] mem [DEPTH];

  // Storage is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module mem_stage #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        EX_regwrite,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic [2:0]  EX_funct3,
  input  logic [4:0]  EX_rd,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] EX_store_data,
  output logic        MEM_regwrite,
  output logic [4:0]  MEM_rd,
  output logic [31:0] MEM_data,
  output logic        fault,
  output logic        fault_sticky,
  output logic [31:0] fault_addr
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 4;

  // Decoded view of the incoming access.
  typedef struct packed {
    logic          rd_en;
    logic          wr_en;
    logic [2:0]    f3;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          oor;
  } mem_req_t;

  // Next-cycle values for the MEM boundary.
  typedef struct packed {
    logic        regwrite;
    logic [31:0] data;
    logic        fault;
  } mem_rsp_t;

  mem_req_t req;
  mem_rsp_t rsp;

  logic                          size_bad;
  logic                          f3_bad;
  logic                          fault_now;
  logic                          commit;
  logic [NUM_LANES-1:0]          lane_be;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     lane_wdata;
  logic [NUM_LANES-1:0][7:0]     lane_rdata;
  logic [31:0]                   rword;
  logic [31:0]                   rshift;
  logic [15:0]                   rhalf;
  logic [31:0]                   load_data;

  assign req.rd_en = EX_memread;
  assign req.wr_en = EX_memwrite;
  assign req.f3    = EX_funct3;
  assign req.idx   = EX_alu_result[AW+1:2];
  assign req.off   = EX_alu_result[1:0];
  assign req.oor   = |EX_alu_result[31:AW+2];

  // Access checks: alignment by size, legal funct3 per direction, range and
  // the read+write conflict. Only meaningful for memory instructions.
  always_comb begin
    size_bad = 1'b0;
    case (req.f3[1:0])
      2'b01:   size_bad = req.off[0];
      2'b10:   size_bad = |req.off;
      default: size_bad = 1'b0;
    endcase
    f3_bad = 1'b0;
    if (req.rd_en && !(req.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      f3_bad = 1'b1;
    if (req.wr_en && !(req.f3 inside {3'b000, 3'b001, 3'b010}))
      f3_bad = 1'b1;
    fault_now = (req.rd_en || req.wr_en) &&
                (size_bad || f3_bad || req.oor || (req.rd_en && req.wr_en));
  end

  // Store lane enables and lane-replicated write data; the addressed lanes
  // pick up the low byte/half of the store data.
  always_comb begin
    lane_be    = '0;
    lane_wdata = EX_store_data;
    case (req.f3[1:0])
      2'b00: begin
        lane_be[req.off]   = 1'b1;
        lane_wdata         = {4{EX_store_data[7:0]}};
      end
      2'b01: begin
        lane_be[{req.off[1], 1'b0} +: 2] = 2'b11;
        lane_wdata         = {2{EX_store_data[15:0]}};
      end
      2'b10:   lane_be = '1;
      default: lane_be = '0;
    endcase
  end

  // A store commits only when not stalled, not rejected and not in reset.
  assign commit  = req.wr_en && !fault_now && !stall && !reset;
  assign lane_we = lane_be & {NUM_LANES{commit}};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mem_stage_lane #(.DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (req.idx),
      .wdata (lane_wdata[l]),
      .rdata (lane_rdata[l])
    );
  end

  assign rword  = lane_rdata;
  assign rshift = rword >> {req.off, 3'b000};
  assign rhalf  = req.off[1] ? rword[31:16] : rword[15:0];

  // Load formatting: lane select plus sign or zero extension.
  always_comb begin
    load_data = '0;
    case (req.f3)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b010:  load_data = rword;
      3'b100:  load_data = {24'd0, rshift[7:0]};
      3'b101:  load_data = {16'd0, rhalf};
      default: load_data = '0;
    endcase
  end

  // Result selection: rejected accesses drop their write-back, stores never
  // write back, loads return memory data, everything else passes through.
  always_comb begin
    rsp.fault    = fault_now;
    rsp.regwrite = EX_regwrite;
    rsp.data     = EX_alu_result;
    if (fault_now) begin
      rsp.regwrite = 1'b0;
      rsp.data     = '0;
    end else if (req.wr_en) begin
      rsp.regwrite = 1'b0;
    end else if (req.rd_en) begin
      rsp.data     = load_data;
    end
  end

  // MEM boundary registers; a stall holds everything except the fault pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MEM_regwrite <= 1'b0;
      MEM_rd       <= '0;
      MEM_data     <= '0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
    end else if (stall) begin
      fault        <= 1'b0;
    end else begin
      MEM_regwrite <= rsp.regwrite;
      MEM_rd       <= EX_rd;
      MEM_data     <= rsp.data;
      fault        <= rsp.fault;
      if (rsp.fault) begin
        fault_sticky <= 1'b1;
        fault_addr   <= EX_alu_result;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed reference model checked every cycle,
// plus directed operations with hand-computed literal expectations.
module tb_mem_stage;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        EX_regwrite = 1'b0, EX_memread = 1'b0, EX_memwrite = 1'b0;
  logic [2:0]  EX_funct3 = '0;
  logic [4:0]  EX_rd = '0;
  logic [31:0] EX_alu_result = '0, EX_store_data = '0;
  logic        MEM_regwrite, fault, fault_sticky;
  logic [4:0]  MEM_rd;
  logic [31:0] MEM_data, fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .EX_regwrite(EX_regwrite), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_funct3(EX_funct3), .EX_rd(EX_rd), .EX_alu_result(EX_alu_result),
    .EX_store_data(EX_store_data),
    .MEM_regwrite(MEM_regwrite), .MEM_rd(MEM_rd), .MEM_data(MEM_data),
    .fault(fault), .fault_sticky(fault_sticky), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0]    mb [0:4*DEPTH-1];
  logic        e_rw = 1'b0, e_fault = 1'b0, e_sticky = 1'b0, e_dc = 1'b0;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0, e_faddr = '0;

  task automatic model_step();
    int          n;
    bit          bad;
    logic [31:0] a;
    logic [31:0] v;
    a   = EX_alu_result;
    n   = 1 << EX_funct3[1:0];
    bad = 1'b0;
    if (EX_memread || EX_memwrite) begin
      if (EX_memread && EX_memwrite) bad = 1'b1;
      if (EX_memread && !(EX_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
      if (EX_memwrite && !(EX_funct3 inside {3'd0, 3'd1, 3'd2})) bad = 1'b1;
      if (a >= 32'(4 * DEPTH)) bad = 1'b1;
      if ((a % 32'(n)) != 0) bad = 1'b1;
    end
    e_fault = bad;
    e_rd    = EX_rd;
    e_dc    = 1'b0;
    if (bad) begin
      e_rw = 1'b0; e_data = '0; e_sticky = 1'b1; e_faddr = a;
    end else if (EX_memwrite) begin
      for (int i = 0; i < n; i++) mb[a + 32'(i)] = EX_store_data[8*i +: 8];
      e_rw = 1'b0; e_dc = 1'b1;
    end else if (EX_memread) begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a + 32'(i)];
      if (!EX_funct3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!EX_funct3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      e_rw = EX_regwrite; e_data = v;
    end else begin
      e_rw = EX_regwrite; e_data = a;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      e_rw = 1'b0; e_rd = '0; e_data = '0; e_fault = 1'b0;
      e_sticky = 1'b0; e_faddr = '0; e_dc = 1'b0;
    end else if (stall) begin
      e_fault = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("m_regwrite", 32'(MEM_regwrite), 32'(e_rw));
    chk("m_rd", 32'(MEM_rd), 32'(e_rd));
    if (!e_dc) chk("m_data", MEM_data, e_data);
    chk("m_fault", 32'(fault), 32'(e_fault));
    chk("m_sticky", 32'(fault_sticky), 32'(e_sticky));
    chk("m_faddr", fault_addr, e_faddr);
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input bit w, input bit r, input bit s, input logic [2:0] f,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] dat,
                       input bit st);
    EX_regwrite = w; EX_memread = r; EX_memwrite = s; EX_funct3 = f;
    EX_rd = d; EX_alu_result = a; EX_store_data = dat; stall = st;
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [2:0] f, input logic [4:0] d, input logic [31:0] a);
    issue(1'b1, 1'b1, 1'b0, f, d, a, 32'h0, 1'b0);
  endtask

  task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] dat);
    issue(1'b1, 1'b0, 1'b1, f, 5'd9, a, dat, 1'b0);
  endtask

  task automatic nop(input logic [4:0] d, input logic [31:0] a);
    issue(1'b1, 1'b0, 1'b0, 3'd0, d, a, 32'h0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("rst_rd", 32'(MEM_rd), 32'd0);
    chk("rst_data", MEM_data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_sticky", 32'(fault_sticky), 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    reset = 1'b0;

    st(3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_regwrite", 32'(MEM_regwrite), 32'd0);
    ld(3'b010, 5'd5, 32'h10);
    chk("lw_regwrite", 32'(MEM_regwrite), 32'd1);
    chk("lw_rd", 32'(MEM_rd), 32'd5);
    chk("lw_data", MEM_data, 32'hDEADBEEF);
    ld(3'b000, 5'd1, 32'h13);  chk("lb", MEM_data, 32'hFFFFFFDE);
    ld(3'b100, 5'd1, 32'h13);  chk("lbu", MEM_data, 32'h000000DE);
    ld(3'b001, 5'd1, 32'h12);  chk("lh", MEM_data, 32'hFFFFDEAD);
    ld(3'b101, 5'd1, 32'h10);  chk("lhu", MEM_data, 32'h0000BEEF);

    st(3'b000, 32'h11, 32'hAAAAAA55);
    ld(3'b010, 5'd2, 32'h10);  chk("sb_merge", MEM_data, 32'hDEAD55EF);
    st(3'b001, 32'h12, 32'hFFFF1234);
    ld(3'b010, 5'd2, 32'h10);  chk("sh_merge", MEM_data, 32'h123455EF);

    st(3'b010, 32'h000, 32'h0BADF00D);
    st(3'b010, 32'h3FC, 32'hA5A5A5A5);
    ld(3'b010, 5'd3, 32'h3FC); chk("lw_top", MEM_data, 32'hA5A5A5A5);

    ld(3'b010, 5'd3, 32'h0E);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("mis_data", MEM_data, 32'd0);
    chk("mis_faddr", fault_addr, 32'h0E);
    nop(5'd2, 32'h1);
    chk("pulse_end", 32'(fault), 32'd0);
    chk("sticky_hold", 32'(fault_sticky), 32'd1);
    st(3'b010, 32'h400, 32'hFFFFFFFF);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_faddr", fault_addr, 32'h400);
    ld(3'b010, 5'd4, 32'h000); chk("oor_nowrite", MEM_data, 32'h0BADF00D);

    ld(3'b011, 5'd4, 32'h10);  chk("ld_f3_bad", 32'(fault), 32'd1);
    st(3'b100, 32'h10, 32'h0); chk("st_f3_bad", 32'(fault), 32'd1);
    issue(1'b1, 1'b1, 1'b1, 3'b010, 5'd4, 32'h10, 32'h0, 1'b0);
    chk("rd_wr_both", 32'(fault), 32'd1);
    st(3'b001, 32'h11, 32'h0);
    ld(3'b001, 5'd4, 32'h13);
    ld(3'b101, 5'd4, 32'h11);
    st(3'b010, 32'h12, 32'h0);
    ld(3'b010, 5'd4, 32'h10);  chk("rejects_nowrite", MEM_data, 32'h123455EF);

    st(3'b010, 32'h20, 32'h0);
    st(3'b000, 32'h20, 32'h11);
    st(3'b001, 32'h22, 32'h3344);
    ld(3'b010, 5'd6, 32'h20);  chk("b2b_stores", MEM_data, 32'h33440011);

    nop(5'd7, 32'h42);
    chk("pass_data", MEM_data, 32'h42);
    chk("pass_rd", 32'(MEM_rd), 32'd7);
    chk("pass_regwrite", 32'(MEM_regwrite), 32'd1);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h20, 32'h99, 1'b1);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h20, 32'h99, 1'b1);
    chk("stall_data", MEM_data, 32'h42);
    chk("stall_rd", 32'(MEM_rd), 32'd7);
    ld(3'b010, 5'd6, 32'h20);  chk("stall_nowrite", MEM_data, 32'h33440011);

    ld(3'b010, 5'd4, 32'h21);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h20, 32'h77, 1'b1);
    chk("stall_fault0", 32'(fault), 32'd0);
    chk("stall_faddr", fault_addr, 32'h21);

    EX_regwrite = 1'b1; EX_memread = 1'b0; EX_memwrite = 1'b1; EX_funct3 = 3'b010;
    EX_rd = 5'd9; EX_alu_result = 32'h20; EX_store_data = 32'hCAFEBABE; stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("mid_rst_data", MEM_data, 32'd0);
    chk("mid_rst_sticky", 32'(fault_sticky), 32'd0);
    chk("mid_rst_faddr", fault_addr, 32'd0);
    @(posedge clk); #1;
    EX_memwrite = 1'b0; EX_regwrite = 1'b0;
    reset = 1'b0;
    ld(3'b010, 5'd6, 32'h20);  chk("rst_nocommit", MEM_data, 32'h33440011);
    nop(5'd0, 32'h0);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
